// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-port data-memory responder for the memory stage. Accepts one
//   load/store at a time over a valid/ready handshake. After LATENCY cycles it
//   returns a right-aligned, zero-extended load result or a store
//   acknowledgement. Sub-word stores are byte-lane merged. Misaligned,
//   out-of-range and illegal-size accesses set resp_err.
//
//   Ports
//     clk, resetn            : clock, asynchronous active-low reset
//     req_valid / req_ready  : request handshake
//     req_write              : 1 = store, 0 = load
//     req_size               : 1=8b, 2=16b, 3=32b, 4=64b (others illegal)
//     req_addr               : byte address
//     req_wdata              : right-aligned store data
//     resp_valid / resp_ready: response handshake
//     resp_data              : right-aligned load data (0 for stores/errors)
//     resp_err               : access faulted
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;

  logic        r_write;
  logic [2:0]  r_size;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;

  logic [63:0] r_resp_data;
  logic        r_resp_err;

  logic [63:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_go_resp;

  logic        w_sel_write;
  logic [2:0]  w_sel_size;
  logic [63:0] w_sel_addr;
  logic [63:0] w_sel_wdata;

  logic [3:0]  w_nbytes;
  logic        w_size_ok;
  logic        w_align_ok;
  logic [63:0] w_off;
  logic        w_below;
  logic        w_oor;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [2:0]  w_byte_off;
  logic [7:0]  w_nmask;
  logic [7:0]  w_lane;
  logic [63:0] w_dmask;
  logic [63:0] w_wshift;
  logic [63:0] w_rword;
  logic [63:0] w_merged;
  logic [63:0] w_rdata;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_go_resp = 1'b0;
    req_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next    = S_RESP;
            w_go_resp = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next    = S_RESP;
          w_go_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

  // Latency counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_INIT;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_write <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_size  <= req_size;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // With LATENCY=1 the array is accessed on the accept edge itself, so the
  // access path takes the live request in IDLE and the held copy otherwise.
  // The held fields never change, so the error result is the accept-time one.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_sel_write = req_write;
      w_sel_size  = req_size;
      w_sel_addr  = req_addr;
      w_sel_wdata = req_wdata;
    end else begin
      w_sel_write = r_write;
      w_sel_size  = r_size;
      w_sel_addr  = r_addr;
      w_sel_wdata = r_wdata;
    end
  end

  // Access decode and fault checks
  always_comb begin
    w_nbytes   = 4'd0;
    w_size_ok  = 1'b1;
    w_align_ok = 1'b1;
    unique case (w_sel_size)
      3'd1: w_nbytes = 4'd1;
      3'd2: begin
        w_nbytes   = 4'd2;
        w_align_ok = (w_sel_addr[0] == 1'b0);
      end
      3'd3: begin
        w_nbytes   = 4'd4;
        w_align_ok = (w_sel_addr[1:0] == 2'b00);
      end
      3'd4: begin
        w_nbytes   = 4'd8;
        w_align_ok = (w_sel_addr[2:0] == 3'b000);
      end
      default: w_size_ok = 1'b0;
    endcase
  end

  assign w_off      = w_sel_addr - BASE_ADDR;
  assign w_below    = (w_sel_addr < BASE_ADDR);
  assign w_oor      = ((w_off >> 3) >= 64'(DEPTH_WORDS));
  assign w_err      = !w_size_ok || !w_align_ok || w_below || w_oor;
  assign w_idx      = w_off[AW+2:3];
  assign w_byte_off = w_sel_addr[2:0];

  // Lane masks; alignment guarantees offset+bytes never exceeds 8 when legal.
  assign w_nmask  = 8'((16'h1 << w_nbytes) - 16'h1);
  assign w_lane   = w_nmask << w_byte_off;
  assign w_wshift = w_sel_wdata << {w_byte_off, 3'b000};
  assign w_rword  = r_mem[w_idx];

  always_comb begin
    w_dmask  = '0;
    w_merged = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_dmask[8*i +: 8]  = w_nmask[i] ? 8'hFF : 8'h00;
      w_merged[8*i +: 8] = w_lane[i] ? w_wshift[8*i +: 8] : w_rword[8*i +: 8];
    end
  end

  assign w_rdata = (w_rword >> {w_byte_off, 3'b000}) & w_dmask;

  // Storage: not reset; store commits on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (w_go_resp && w_sel_write && !w_err) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Response registers: loaded entering RESP, cleared on handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_go_resp) begin
      r_resp_data <= (w_sel_write || w_err) ? 64'd0 : w_rdata;
      r_resp_err  <= w_err;
    end else if (r_state == S_RESP && resp_ready) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (64'h8000_0000),
    .LATENCY    (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction at LATENCY=2; optionally holds resp_ready low for
  // 'hold' cycles in RESP while a junk request is offered.
  task automatic xact(input string tag, input logic w, input logic [2:0] sz,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] ed, input logic ee, input int hold);
    chk({tag, ".ready_pre"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    step();                                   // accept edge T
    req_valid = 1'b0;
    req_addr  = 64'hFFFF_FFFF_FFFF_FFF0;
    chk({tag, ".valid_T"}, 64'(resp_valid), 64'd0);
    chk({tag, ".ready_T"}, 64'(req_ready), 64'd0);
    step();                                   // T+1
    chk({tag, ".valid_T1"}, 64'(resp_valid), 64'd0);
    step();                                   // T+2
    chk({tag, ".valid_T2"}, 64'(resp_valid), 64'd1);
    chk({tag, ".data"}, resp_data, ed);
    chk({tag, ".err"}, 64'(resp_err), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 3'd4;
      req_addr  = 64'h8000_0008;
      req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      chk($sformatf("%s.hold%0d_valid", tag, i), 64'(resp_valid), 64'd1);
      chk($sformatf("%s.hold%0d_data", tag, i), resp_data, ed);
      chk($sformatf("%s.hold%0d_ready", tag, i), 64'(req_ready), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();                                   // handshake edge R
    resp_ready = 1'b0;
    chk({tag, ".valid_post"}, 64'(resp_valid), 64'd0);
    chk({tag, ".ready_post"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) step();
    resetn = 1'b1;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst%0d.ready", i), 64'(req_ready), 64'd1);
      chk($sformatf("rst%0d.valid", i), 64'(resp_valid), 64'd0);
      chk($sformatf("rst%0d.data", i), resp_data, 64'd0);
      chk($sformatf("rst%0d.err", i), 64'(resp_err), 64'd0);
    end

    // 64-bit store/load
    xact("sd8", 1'b1, 3'd4, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 0);
    xact("ld8", 1'b0, 3'd4, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 0);

    // Sub-word merge: byte 3 <- AA, bytes 6..7 <- BEEF
    xact("sb_b", 1'b1, 3'd1, 64'h8000_000B, 64'hFFFF_FFFF_FFFF_FFAA, 64'd0, 1'b0, 0);
    xact("sh_e", 1'b1, 3'd2, 64'h8000_000E, 64'h0000_0000_0000_BEEF, 64'd0, 1'b0, 0);
    xact("ld8m", 1'b0, 3'd4, 64'h8000_0008, 64'd0, 64'hBEEF_3344_AA66_7788, 1'b0, 0);
    xact("lw_c", 1'b0, 3'd3, 64'h8000_000C, 64'd0, 64'h0000_0000_BEEF_3344, 1'b0, 0);
    xact("lh_a", 1'b0, 3'd2, 64'h8000_000A, 64'd0, 64'h0000_0000_0000_AA66, 1'b0, 0);
    xact("lb_f", 1'b0, 3'd1, 64'h8000_000F, 64'd0, 64'h0000_0000_0000_00BE, 1'b0, 0);

    // Faults
    xact("lw_mis",  1'b0, 3'd3, 64'h8000_0002, 64'd0, 64'd0, 1'b1, 0);
    xact("sh_mis",  1'b1, 3'd2, 64'h8000_0009, 64'h1234, 64'd0, 1'b1, 0);
    xact("sd_low",  1'b1, 3'd4, 64'h7FFF_FFF8, 64'hDEAD_BEEF, 64'd0, 1'b1, 0);
    xact("sz0_st",  1'b1, 3'd0, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
    xact("sz7_st",  1'b1, 3'd7, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
    xact("ld8_chk", 1'b0, 3'd4, 64'h8000_0008, 64'd0, 64'hBEEF_3344_AA66_7788, 1'b0, 0);

    // Top-of-range boundary
    xact("sd_last", 1'b1, 3'd4, 64'h8000_1FF8, 64'hCAFE_F00D_0BAD_BEEF, 64'd0, 1'b0, 0);
    xact("ld_last", 1'b0, 3'd4, 64'h8000_1FF8, 64'd0, 64'hCAFE_F00D_0BAD_BEEF, 1'b0, 0);
    xact("sd_oor",  1'b1, 3'd4, 64'h8000_2000, 64'h1, 64'd0, 1'b1, 0);
    xact("ld_oor",  1'b0, 3'd4, 64'h8000_2000, 64'd0, 64'd0, 1'b1, 0);

    // Backpressure: 4 cycles with resp_ready low, junk store offered
    xact("bp", 1'b0, 3'd4, 64'h8000_0008, 64'd0, 64'hBEEF_3344_AA66_7788, 1'b0, 4);
    xact("bp_chk", 1'b0, 3'd4, 64'h8000_0008, 64'd0, 64'hBEEF_3344_AA66_7788, 1'b0, 0);

    // Reset mid-operation
    xact("sd10", 1'b1, 3'd4, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 3'd4;
    req_addr  = 64'h8000_0010;
    req_wdata = 64'h0000_0000_0000_DEAD;
    step();                                   // accepted, now in WAIT
    req_valid = 1'b0;
    resetn    = 1'b0;
    #1;
    chk("abort.valid_rst", 64'(resp_valid), 64'd0);
    chk("abort.ready_rst", 64'(req_ready), 64'd1);
    step();
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("abort%0d.valid", i), 64'(resp_valid), 64'd0);
    end
    xact("ld10", 1'b0, 3'd4, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
